// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, defaults and leading-zero helper for seg_scan_ctrl
package seg_scan_pkg;

   localparam int DEF_NUM_DIGITS  = 4;
   localparam int DEF_REFRESH_DIV = 50000;
   localparam int DEF_GUARD       = 2;

   // Widest display the leading-zero helper can inspect.
   localparam int LZ_MAX_DIGITS   = 16;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Digit idx is a leading zero when it is not digit 0 and it and every higher
   // digit (below n) hold 0.
   function automatic logic lz_blank(input logic [4*LZ_MAX_DIGITS-1:0] v,
                                     input int                         n,
                                     input int                         idx);
      logic nonzero;
      nonzero = 1'b0;
      for (int i = 0; i < LZ_MAX_DIGITS; i++) begin
         if (i >= idx && i < n && v[4*i +: 4] != 4'd0) begin
            nonzero = 1'b1;
         end
      end
      return (idx != 0) && !nonzero;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// rtl/seg_scan_ctrl_scan_timer.sv - slot counter, digit index, blank/drive state and frame pulse
module scan_timer
   import seg_scan_pkg::*;
#(
   parameter  int NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter  int REFRESH_DIV = DEF_REFRESH_DIV,
   parameter  int GUARD       = DEF_GUARD,
   localparam int IW          = $clog2(NUM_DIGITS)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   output logic [IW-1:0] idx_d_o,
   output scan_state_e   state_d_o,
   output logic          boundary_o,
   output logic          frame_done_o
);

   localparam int              CW        = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]   CNT_GUARD = CW'(GUARD);
   localparam logic [IW-1:0]   IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   scan_state_e   state_q, state_d;
   logic          frame_done_q;
   logic          slot_end;

   // Next-state for the counters and the per-slot blank/drive FSM.
   always_comb begin
      slot_end = (cnt_q == CNT_LAST);
      cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
      idx_d    = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (cnt_d >= CNT_GUARD) state_d = ST_DRIVE;
         ST_DRIVE: if (slot_end && GUARD > 0) state_d = ST_BLANK;
         default:  state_d = ST_BLANK;
      endcase
   end

   // Counter, index and state registers; frame_done marks the cycle after the wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         state_q      <= ST_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         state_q      <= state_d;
         frame_done_q <= boundary_o;
      end
   end

   assign boundary_o   = slot_end && (idx_q == IDX_LAST);
   assign idx_d_o      = idx_d;
   assign state_d_o    = state_d;
   assign frame_done_o = frame_done_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed BCD display scanner with frame-synchronous value commit
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int REFRESH_DIV = DEF_REFRESH_DIV,
   parameter int GUARD       = DEF_GUARD
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    blank_lz,
   output logic [3:0]              nib,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int IW  = $clog2(NUM_DIGITS);
   localparam int DW  = 4 * NUM_DIGITS;
   localparam int LZW = 4 * LZ_MAX_DIGITS;

   logic [IW-1:0]         idx_d;
   scan_state_e           state_d;
   logic                  boundary;
   logic [DW-1:0]         disp_q, disp_d;
   logic [DW-1:0]         shadow_q, shadow_d;
   logic                  pending_q, pending_d;
   logic [3:0]            nib_q, nib_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  blanked;

   scan_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .GUARD       (GUARD)
   ) u_timer (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .idx_d_o      (idx_d),
      .state_d_o    (state_d),
      .boundary_o   (boundary),
      .frame_done_o (frame_done)
   );

   // Double buffer: loads land in shadow; the display only changes on the frame wrap,
   // and a load on the wrap cycle goes straight to the display.
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      disp_d    = disp_q;
      if (load) begin
         shadow_d = value;
      end
      if (boundary) begin
         pending_d = 1'b0;
         if (load) begin
            disp_d = value;
         end else if (pending_q) begin
            disp_d = shadow_q;
         end
      end else if (load) begin
         pending_d = 1'b1;
      end
   end

   // Outputs are computed from next-state so the registered an/nib match the slot they belong to.
   always_comb begin
      nib_d   = disp_d[{idx_d, 2'b00} +: 4];
      blanked = blank_lz && lz_blank(LZW'(disp_d), NUM_DIGITS, int'(idx_d));
      an_d    = '1;
      if (state_d == ST_DRIVE && !blanked) begin
         an_d[idx_d] = 1'b0;
      end
   end

   // Value buffers and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q    <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         nib_q     <= '0;
         an_q      <= '1;
      end else begin
         disp_q    <= disp_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         nib_q     <= nib_d;
         an_q      <= an_d;
      end
   end

   assign nib     = nib_q;
   assign an      = an_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots, guard 2)
module tb_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int G  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [15:0]   value;
   logic          blank_lz;
   logic [3:0]    nib;
   logic [ND-1:0] an;
   logic          pending;
   logic          frame_done;

   seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .GUARD       (G)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .blank_lz   (blank_lz),
      .nib        (nib),
      .an         (an),
      .pending    (pending),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      nm;
      logic [3:0] an;
      logic [3:0] nib;
      logic       pend;
      logic       fd;
   } exp_t;

   exp_t sb[$];
   int   t      = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic tick();
      @(posedge clk);
      t++;
      #1;
   endtask

   task automatic goto(input int c);
      while (t < c) tick();
   endtask

   task automatic expect_at(input int c, input string nm, input logic [3:0] a,
                            input logic [3:0] n, input logic p, input logic f);
      exp_t e;
      e.cyc = c; e.nm = nm; e.an = a; e.nib = n; e.pend = p; e.fd = f;
      sb.push_back(e);
   endtask

   task automatic load_at(input int c, input logic [15:0] v);
      goto(c);
      value = v;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   // Monitor: compare every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc < t) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d not checked, now cycle %0d", sb[i].nm, sb[i].cyc, t);
            sb.delete(i);
         end else if (sb[i].cyc == t) begin
            checks++;
            if (an !== sb[i].an || nib !== sb[i].nib || pending !== sb[i].pend || frame_done !== sb[i].fd) begin
               errors++;
               $display("FAIL %s cycle %0d: got an=%b nib=%h pending=%b frame_done=%b, expected an=%b nib=%h pending=%b frame_done=%b",
                        sb[i].nm, t, an, nib, pending, frame_done, sb[i].an, sb[i].nib, sb[i].pend, sb[i].fd);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      int r, b1, b2, b3, b4, b5, b6, r2;
      rst_n    = 1'b0;
      load     = 1'b0;
      value    = 16'h0;
      blank_lz = 1'b0;
      r  = 3;
      b1 = r + 32; b2 = b1 + 32; b3 = b2 + 32; b4 = b3 + 32; b5 = b4 + 32; b6 = b5 + 32;

      // Reset state and the free-running scan with no value loaded.
      expect_at(2,      "rst_state", 4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(r,      "t1_c0",     4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(r + 1,  "t1_c1",     4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(r + 2,  "t1_c2",     4'hE, 4'h0, 1'b0, 1'b0);
      expect_at(r + 7,  "t1_c7",     4'hE, 4'h0, 1'b0, 1'b0);
      expect_at(r + 8,  "t1_c8",     4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(r + 10, "t1_c10",    4'hD, 4'h0, 1'b0, 1'b0);
      expect_at(r + 31, "t1_c31",    4'h7, 4'h0, 1'b0, 1'b0);
      expect_at(r + 32, "t1_fd",     4'hF, 4'h0, 1'b0, 1'b1);
      expect_at(r + 33, "t1_c33",    4'hF, 4'h0, 1'b0, 1'b0);
      goto(r);
      rst_n = 1'b1;

      // Load 1234 mid-frame: held in shadow until the next wrap.
      goto(b1 + 5);
      expect_at(b1 + 5,  "t2_ld",   4'hE, 4'h0, 1'b0, 1'b0);
      expect_at(b1 + 6,  "t2_pend", 4'hE, 4'h0, 1'b1, 1'b0);
      expect_at(b1 + 10, "t2_hold", 4'hD, 4'h0, 1'b1, 1'b0);
      expect_at(b1 + 31, "t2_pre",  4'h7, 4'h0, 1'b1, 1'b0);
      expect_at(b2,      "t2_fd",   4'hF, 4'h4, 1'b0, 1'b1);
      expect_at(b2 + 2,  "t2_s0",   4'hE, 4'h4, 1'b0, 1'b0);
      expect_at(b2 + 10, "t2_s1",   4'hD, 4'h3, 1'b1, 1'b0);
      expect_at(b2 + 18, "t2_s2",   4'hB, 4'h2, 1'b1, 1'b0);
      expect_at(b2 + 26, "t2_s3",   4'h7, 4'h1, 1'b1, 1'b0);
      load_at(b1 + 5, 16'h1234);

      // Two loads in one frame: the last one wins.
      goto(b2 + 3);
      expect_at(b2 + 4,  "t3_pend", 4'hE, 4'h4, 1'b1, 1'b0);
      expect_at(b3 - 1,  "t3_pre",  4'h7, 4'h1, 1'b1, 1'b0);
      expect_at(b3,      "t3_fd",   4'hF, 4'h8, 1'b0, 1'b1);
      expect_at(b3 + 2,  "t3_s0",   4'hE, 4'h8, 1'b0, 1'b0);
      expect_at(b3 + 10, "t3_s1",   4'hD, 4'h7, 1'b1, 1'b0);
      expect_at(b3 + 18, "t3_s2",   4'hB, 4'h6, 1'b1, 1'b0);
      expect_at(b3 + 26, "t3_s3",   4'h7, 4'h5, 1'b1, 1'b0);
      load_at(b2 + 3,  16'h1111);
      load_at(b2 + 20, 16'h5678);

      // Leading-zero blanking on 0070, then on 0000, then blanking switched off mid-slot.
      goto(b3 + 4);
      expect_at(b4,      "t4_fd",     4'hF, 4'h0, 1'b0, 1'b1);
      expect_at(b4 + 2,  "t4_s0",     4'hE, 4'h0, 1'b0, 1'b0);
      expect_at(b4 + 10, "t4_s1",     4'hD, 4'h7, 1'b1, 1'b0);
      expect_at(b4 + 18, "t4_s2_blk", 4'hF, 4'h0, 1'b1, 1'b0);
      expect_at(b4 + 26, "t4_s3_blk", 4'hF, 4'h0, 1'b1, 1'b0);
      expect_at(b5 + 2,  "t4_z_s0",   4'hE, 4'h0, 1'b0, 1'b0);
      expect_at(b5 + 10, "t4_z_s1",   4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(b5 + 11, "t4_lz_chg", 4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(b5 + 12, "t4_lz_off", 4'hD, 4'h0, 1'b0, 1'b0);
      expect_at(b5 + 18, "t4_z_s2",   4'hB, 4'h0, 1'b0, 1'b0);
      expect_at(b5 + 26, "t4_z_s3",   4'h7, 4'h0, 1'b0, 1'b0);
      load_at(b3 + 4, 16'h0070);
      goto(b3 + 28);
      blank_lz = 1'b1;
      load_at(b4 + 5, 16'h0000);
      goto(b5 + 11);
      blank_lz = 1'b0;

      // Load on the wrap cycle bypasses the shadow; pending never rises.
      goto(b5 + 31);
      expect_at(b5 + 31, "t5_wrap", 4'h7, 4'h0, 1'b0, 1'b0);
      expect_at(b6,      "t5_fd",   4'hF, 4'h9, 1'b0, 1'b1);
      expect_at(b6 + 2,  "t5_s0",   4'hE, 4'h9, 1'b0, 1'b0);
      expect_at(b6 + 10, "t5_s1",   4'hD, 4'h9, 1'b1, 1'b0);
      load_at(b5 + 31, 16'h9999);

      // Asynchronous reset mid-slot with a value pending: everything cleared, pending value lost.
      goto(b6 + 5);
      r2 = b6 + 15;
      expect_at(b6 + 12, "t6_pre",   4'hD, 4'h9, 1'b1, 1'b0);
      expect_at(b6 + 13, "t6_async", 4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(b6 + 14, "t6_held",  4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(r2,      "t6_c0",    4'hF, 4'h0, 1'b0, 1'b0);
      expect_at(r2 + 2,  "t6_c2",    4'hE, 4'h0, 1'b0, 1'b0);
      expect_at(r2 + 10, "t6_c10",   4'hD, 4'h0, 1'b0, 1'b0);
      expect_at(r2 + 32, "t6_fd",    4'hF, 4'h0, 1'b0, 1'b1);
      expect_at(r2 + 34, "t6_c34",   4'hE, 4'h0, 1'b0, 1'b0);
      load_at(b6 + 5, 16'h4321);
      goto(b6 + 13);
      rst_n = 1'b0;
      goto(r2);
      rst_n = 1'b1;

      for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations still queued, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
